eth_tx_frame_scheduler: RTL

//  Round-robin scheduler sharing the single Ethernet TX packager between NUM_REQ byte-stream

---
 rtl/eth_pkg.sv | 26 ++
 rtl/eth_tx_frame_scheduler_rr_arbiter.sv | 30 +++
 rtl/eth_tx_frame_scheduler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet TX frame scheduler.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        PAD    = 2'd2,
        GAP    = 2'd3
    } sched_state_t;

    localparam int ETH_MIN_PAYLOAD = 46;
    localparam int ETH_MAX_PAYLOAD = 1500;
    localparam int ETH_IFG_DIBITS  = 48;

    localparam int CNT_W = 11;
    localparam int IFG_W = 16;

    // Round-robin successor of a requester index, wrapping at num_req.
    function automatic logic [1:0] next_ptr(input logic [1:0] id, input int num_req);
        if (int'(id) >= num_req - 1)
            return 2'd0;
        else
            return id + 2'd1;
    endfunction

endpackage

// File: rtl/eth_tx_frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr with req set.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [1:0]         gnt_idx,
    output logic               gnt_any
);

    // Walk offsets from the pointer; the first live requester wins.
    always_comb begin
        int target;
        gnt_idx = '0;
        gnt_any = 1'b0;
        target  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            target = int'(ptr) + k;
            if (target >= NUM_REQ)
                target = target - NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!gnt_any && req[j] && (j == target)) begin
                    gnt_any = 1'b1;
                    gnt_idx = 2'(j);
                end
            end
        end
    end

endmodule

// File: rtl/eth_tx_frame_scheduler.sv
// Shares one Ethernet TX packager between NUM_REQ byte-stream requesters.
// One requester owns each frame; short payloads are zero-padded, long ones cut.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | packager free, waiting for any request; picks next grant
//  STREAM | forwarding bytes of the granted requester
//  PAD    | payload ended short; emitting 0x00 up to the minimum length
//  GAP    | waiting for tx_busy low, then the inter-frame gap timer
module eth_tx_frame_scheduler
    import eth_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int MIN_PAYLOAD = ETH_MIN_PAYLOAD,
    parameter int MAX_PAYLOAD = ETH_MAX_PAYLOAD,
    parameter int IFG_CYCLES  = ETH_IFG_DIBITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   src_valid,
    input  logic [NUM_REQ-1:0]   src_last,
    input  logic [8*NUM_REQ-1:0] src_data,
    output logic [NUM_REQ-1:0]   src_ready,
    input  logic                 tx_busy,
    output logic                 valid_out,
    output logic [7:0]           byte_out,
    output logic                 frame_end,
    output logic [1:0]           grant_id,
    output logic                 truncated
);

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PAYLOAD);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PAYLOAD);
    localparam logic [IFG_W-1:0] IFG_C = IFG_W'(IFG_CYCLES);

    sched_state_t       state;
    logic [1:0]         ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_inc;
    logic [IFG_W-1:0]   ifg_cnt;

    logic [1:0]         arb_idx;
    logic               arb_any;
    logic [NUM_REQ-1:0] arb_onehot;

    logic               cur_valid;
    logic               cur_last;
    logic [7:0]         cur_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req     (src_valid),
        .ptr     (ptr),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign count_inc = count + CNT_W'(1);

    // Select the byte lane of the current owner and decode the pending grant.
    always_comb begin
        cur_valid  = 1'b0;
        cur_last   = 1'b0;
        cur_data   = '0;
        arb_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 2'(i)) begin
                cur_valid = src_valid[i];
                cur_last  = src_last[i];
                cur_data  = src_data[8*i +: 8];
            end
            arb_onehot[i] = (arb_idx == 2'(i));
        end
    end

    // Frame sequencing FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            count     <= '0;
            ifg_cnt   <= '0;
            grant_id  <= '0;
            src_ready <= '0;
            valid_out <= 1'b0;
            byte_out  <= '0;
            frame_end <= 1'b0;
            truncated <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            frame_end <= 1'b0;
            truncated <= 1'b0;
            case (state)
                IDLE: begin
                    if (!tx_busy && arb_any) begin
                        grant_id  <= arb_idx;
                        src_ready <= arb_onehot;
                        count     <= '0;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (cur_valid) begin
                        valid_out <= 1'b1;
                        byte_out  <= cur_data;
                        count     <= count_inc;
                        // src_last outranks the length cut on the same byte
                        if (cur_last) begin
                            src_ready <= '0;
                            if (count_inc >= MIN_C) begin
                                frame_end <= 1'b1;
                                ifg_cnt   <= IFG_C;
                                state     <= GAP;
                            end else begin
                                state <= PAD;
                            end
                        end else if (count_inc == MAX_C) begin
                            src_ready <= '0;
                            frame_end <= 1'b1;
                            truncated <= 1'b1;
                            ifg_cnt   <= IFG_C;
                            state     <= GAP;
                        end
                    end
                end
                PAD: begin
                    valid_out <= 1'b1;
                    byte_out  <= 8'h00;
                    count     <= count_inc;
                    if (count_inc >= MIN_C) begin
                        frame_end <= 1'b1;
                        ifg_cnt   <= IFG_C;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    // gap timer restarts for as long as the packager is busy
                    if (tx_busy) begin
                        ifg_cnt <= IFG_C;
                    end else if (ifg_cnt <= IFG_W'(1)) begin
                        ptr   <= next_ptr(grant_id, NUM_REQ);
                        state <= IDLE;
                    end else begin
                        ifg_cnt <= ifg_cnt - IFG_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
